// File: rtl/output_requantizer.sv
// output_requantizer
// Converts signed fixed-point samples from the matrix multiplier
// (IN_WIDTH bits, IN_FRAC fractional) to OUT_WIDTH bits with OUT_FRAC
// fractional bits. Rounding is round-half-up and the result saturates.
// The block is a two-stage AXI-Stream pipeline with one shared advance enable:
//   stage 1 : sign-extend, add half an output LSB, arithmetic shift right
//   stage 2 : saturate to the output range and drive the output register
// A beat counter marks the last beat of each ROW_LEN-beat row with tlast.
// Optional feature macro: OUTPUT_REQUANT_SAT_CNT_EN adds a sticky 16-bit
// count of saturated output transfers (sat_count), cleared by sat_clr.

module output_requantizer #(
  parameter int IN_WIDTH  = 32,
  parameter int IN_FRAC   = 16,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 10,
  parameter int ROW_LEN   = 512
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  s_axis_input_tdata,
  input  logic                 s_axis_input_tvalid,
  output logic                 s_axis_input_tready,
  output logic [OUT_WIDTH-1:0] m_axis_output_tdata,
  output logic                 m_axis_output_tvalid,
  input  logic                 m_axis_output_tready,
  output logic                 m_axis_output_tlast
`ifdef OUTPUT_REQUANT_SAT_CNT_EN
  ,
  input  logic                 sat_clr,
  output logic [15:0]          sat_count
`endif
);

  localparam int SHIFT = IN_FRAC - OUT_FRAC;
  // One extra bit so adding the rounding constant can never overflow.
  localparam int RW    = IN_WIDTH + 1;
  localparam int CW    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  localparam logic [CW-1:0]        LAST_BEAT = CW'(ROW_LEN - 1);
  localparam logic signed [RW-1:0] RND_HALF  = RW'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0] SAT_MAX   = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  // Two's complement: ~max == -max-1 == most negative output code.
  localparam logic signed [RW-1:0] SAT_MIN   = ~SAT_MAX;

  // Handshake / enable
  logic en;
  logic in_xfer;

  // Stage 1 arithmetic
  logic signed [RW-1:0] x_ext;
  logic signed [RW-1:0] x_rnd;
  logic signed [RW-1:0] r_calc;

  // Stage 2 arithmetic
  logic [OUT_WIDTH-1:0] sat_data;
  logic                 sat_hit;

  // Pipeline registers
  logic                 s1_valid_q, s1_valid_d;
  logic signed [RW-1:0] s1_r_q,     s1_r_d;
  logic                 s1_last_q,  s1_last_d;

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;
  logic                 out_last_q,  out_last_d;

  logic [CW-1:0]        beat_cnt_q,  beat_cnt_d;

`ifdef OUTPUT_REQUANT_SAT_CNT_EN
  logic                 out_xfer;
  logic                 out_sat_q,   out_sat_d;
  logic [15:0]          sat_cnt_q,   sat_cnt_d;
`endif

  // Shared advance enable: the whole pipe moves when the output slot frees up.
  always_comb begin
    en      = !out_valid_q || m_axis_output_tready;
    in_xfer = s_axis_input_tvalid && en;
  end

  // Stage 1 datapath: sign-extend, add half an output LSB, floor-shift.
  always_comb begin
    x_ext  = {s_axis_input_tdata[IN_WIDTH-1], s_axis_input_tdata};
    x_rnd  = x_ext + RND_HALF;
    r_calc = x_rnd >>> SHIFT;
  end

  // Stage 2 datapath: clip the rounded value into the output range.
  always_comb begin
    sat_hit  = 1'b0;
    sat_data = s1_r_q[OUT_WIDTH-1:0];
    if (s1_r_q > SAT_MAX) begin
      sat_hit  = 1'b1;
      sat_data = SAT_MAX[OUT_WIDTH-1:0];
    end else if (s1_r_q < SAT_MIN) begin
      sat_hit  = 1'b1;
      sat_data = SAT_MIN[OUT_WIDTH-1:0];
    end
  end

  // Next-state for the beat counter: counts accepted beats only, wraps per row.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (in_xfer) begin
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // Next-state for both pipeline stages; everything holds while en is low.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_r_d      = s1_r_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (en) begin
      // A bubble on the input becomes an invalid stage 1; data is left as is.
      s1_valid_d = s_axis_input_tvalid;
      s1_last_d  = in_xfer && (beat_cnt_q == LAST_BEAT);
      if (in_xfer) begin
        s1_r_d = r_calc;
      end
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_data_d = sat_data;
      end
    end
  end

  // Pipeline and beat counter registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

`ifdef OUTPUT_REQUANT_SAT_CNT_EN
  // Saturation counter next-state: sticky at all-ones, clear beats increment.
  always_comb begin
    out_xfer  = out_valid_q && m_axis_output_tready;
    out_sat_d = out_sat_q;
    if (en && s1_valid_q) begin
      out_sat_d = sat_hit;
    end
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (out_xfer && out_sat_q && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  // Saturation flag travelling with the output sample, and its counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_sat_q <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      out_sat_q <= out_sat_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`endif

  assign s_axis_input_tready  = en;
  assign m_axis_output_tdata  = out_data_q;
  assign m_axis_output_tvalid = out_valid_q;
  assign m_axis_output_tlast  = out_last_q;

endmodule

// File: tb/tb_output_requantizer.sv
// Self-checking bench for output_requantizer (default parameters).
// Inputs are driven just after the falling edge and everything is sampled
// 1 ns later, so each step() sees the values that the next rising edge uses.
// Expected outputs are queued on each input transfer and popped on each
// output transfer.

module tb_output_requantizer;

  localparam int ROW = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        clr_drv;
`ifdef OUTPUT_REQUANT_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  typedef struct {
    logic [31:0] din;
    logic [15:0] dout;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  int   bcnt;
  int   out_idx;
  int   last_idx[$];
  logic stall_prev;
  logic [15:0] prev_data;
  logic        prev_last;
  vec_t vecs[12];

  always #5 clk = ~clk;

  output_requantizer dut (
    .ap_clk               (clk),
    .ap_rst_n             (rst_n),
    .s_axis_input_tdata   (s_tdata),
    .s_axis_input_tvalid  (s_tvalid),
    .s_axis_input_tready  (s_tready),
    .m_axis_output_tdata  (m_tdata),
    .m_axis_output_tvalid (m_tvalid),
    .m_axis_output_tready (m_tready),
    .m_axis_output_tlast  (m_tlast)
`ifdef OUTPUT_REQUANT_SAT_CNT_EN
    ,
    .sat_clr              (clr_drv),
    .sat_count            (sat_count)
`endif
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor((x + 32) / 64) via truncating division, then clamp.
  function automatic logic [15:0] model(input logic [31:0] x);
    longint v;
    longint q;
    v = $signed(x);
    v = v + 32;
    q = v / 64;
    if ((v % 64 != 0) && (v < 0)) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($signed($urandom_range(0, 255)) - 128);
      2: return 32'h001FFFA0 + 32'($urandom_range(0, 127));
      default: return 32'hFFE00000 - 32'($urandom_range(0, 127));
    endcase
  endfunction

  task automatic monitor(input logic [15:0] e);
    exp_t got;
    if (!rst_n) begin
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tdata", 32'(m_tdata), 32'd0);
      chk("rst_tlast", 32'(m_tlast), 32'd0);
      chk("rst_tready", 32'(s_tready), 32'd1);
`ifdef OUTPUT_REQUANT_SAT_CNT_EN
      chk("rst_sat_count", 32'(sat_count), 32'd0);
`endif
      stall_prev = 1'b0;
      return;
    end
    if (stall_prev) begin
      chk("stall_valid", 32'(m_tvalid), 32'd1);
      chk("stall_data", 32'(m_tdata), 32'(prev_data));
      chk("stall_last", 32'(m_tlast), 32'(prev_last));
    end
    if (s_tvalid && s_tready) begin
      sbq.push_back('{data: e, last: (bcnt == ROW - 1)});
      bcnt = (bcnt == ROW - 1) ? 0 : bcnt + 1;
    end
    if (m_tvalid && m_tready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got 0x%0h expected no output", m_tdata);
      end else begin
        got = sbq.pop_front();
        chk("out_data", 32'(m_tdata), 32'(got.data));
        chk("out_last", 32'(m_tlast), 32'(got.last));
      end
      if (m_tlast) last_idx.push_back(out_idx);
      out_idx++;
    end
    stall_prev = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [15:0] e,
                      input logic rdy, input logic clr);
    @(negedge clk);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = rdy;
    clr_drv  = clr;
    #1;
    monitor(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && sbq.size() > 0; i++) step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0);
    chk({name, "_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  // Asynchronous reset asserted between edges; valid stays high to show
  // nothing is captured while reset is low.
  task automatic hold_reset(input int n);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    bcnt = 0;
    for (int i = 0; i < n; i++) step(1'b1, 32'h00010000, 16'h0400, 1'b1, 1'b0);
    @(negedge clk);
    rst_n      = 1'b1;
    s_tvalid   = 1'b0;
    out_idx    = 0;
    last_idx.delete();
    stall_prev = 1'b0;
  endtask

  initial begin
    logic        pv;
    logic [31:0] pd;
    logic        acc;
    int          n_in;

    vecs[0]  = '{32'h00010000, 16'h0400};
    vecs[1]  = '{32'h0000001F, 16'h0000};
    vecs[2]  = '{32'h00000020, 16'h0001};
    vecs[3]  = '{32'hFFFFFFE0, 16'h0000};
    vecs[4]  = '{32'h7FFFFFFF, 16'h7FFF};
    vecs[5]  = '{32'h80000000, 16'h8000};
    vecs[6]  = '{32'hFFFF0000, 16'hFC00};
    vecs[7]  = '{32'hFFFFFFDF, 16'hFFFF};
    vecs[8]  = '{32'h001FFFDF, 16'h7FFF};
    vecs[9]  = '{32'h001FFFE0, 16'h7FFF};
    vecs[10] = '{32'hFFE00000, 16'h8000};
    vecs[11] = '{32'hFFDFFFDF, 16'h8000};

    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; clr_drv = 1'b0;
    bcnt = 0; out_idx = 0; stall_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
    hold_reset(3);

    // Latency: one beat, output visible two steps later.
    step(1'b1, 32'h00010000, 16'h0400, 1'b1, 1'b0);
    step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0);
    chk("lat_c1_valid", 32'(m_tvalid), 32'd0);
    step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0);
    chk("lat_c2_valid", 32'(m_tvalid), 32'd1);
    chk("lat_c2_data", 32'(m_tdata), 32'h0400);
    drain("latency");

    // Rounding / saturation vectors, back to back.
    foreach (vecs[i]) step(1'b1, vecs[i].din, vecs[i].dout, 1'b1, 1'b0);
    drain("table");

`ifdef OUTPUT_REQUANT_SAT_CNT_EN
    chk("sat_after_table", 32'(sat_count), 32'd4);
    step(1'b0, 32'd0, 16'd0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0);
    chk("sat_clr_idle", 32'(sat_count), 32'd0);
    step(1'b1, 32'h7FFFFFFF, 16'h7FFF, 1'b1, 1'b0);
    step(1'b1, 32'h80000000, 16'h8000, 1'b1, 1'b0);
    drain("sat_pair");
    chk("sat_count_2", 32'(sat_count), 32'd2);
    step(1'b1, 32'h7FFFFFFF, 16'h7FFF, 1'b1, 1'b0);
    step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 16'd0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 16'd0, 1'b1, 1'b0);
    chk("sat_clr_wins", 32'(sat_count), 32'd0);
`endif

    // Two full rows back to back: tlast only on beats 511 and 1023.
    hold_reset(2);
    for (int i = 0; i < 2 * ROW; i++) begin
      pd = rnd_data();
      step(1'b1, pd, model(pd), 1'b1, 1'b0);
    end
    drain("rows");
    chk("tlast_count", 32'(last_idx.size()), 32'd2);
    if (last_idx.size() == 2) begin
      chk("tlast_beat_a", 32'(last_idx[0]), 32'd511);
      chk("tlast_beat_b", 32'(last_idx[1]), 32'd1023);
    end

    // Random valid and ready throttling; AXI-legal hold of offered data.
    pv = 1'b0; pd = '0; acc = 1'b1; n_in = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!pv || acc) begin
        pv = ($urandom_range(0, 1) == 1);
        pd = rnd_data();
      end
      step(pv, pd, model(pd), ($urandom_range(0, 1) == 1), 1'b0);
      acc = pv && s_tready;
      if (acc) n_in++;
    end
    drain("random");
    chk("random_count", 32'(out_idx), 32'(n_in + 2 * ROW));

    // Reset at beat 300 of a row, then a fresh row starts at beat 0.
    hold_reset(1);
    for (int i = 0; i < 300; i++) begin
      pd = rnd_data();
      step(1'b1, pd, model(pd), 1'b1, 1'b0);
    end
    hold_reset(3);
    for (int i = 0; i < ROW; i++) begin
      pd = rnd_data();
      step(1'b1, pd, model(pd), 1'b1, 1'b0);
    end
    drain("post_reset");
    chk("post_reset_out_count", 32'(out_idx), 32'(ROW));
    chk("post_reset_tlast_count", 32'(last_idx.size()), 32'd1);
    if (last_idx.size() == 1) chk("post_reset_tlast_beat", 32'(last_idx[0]), 32'(ROW - 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_requantizer.md
OUTPUT_REQUANTIZER -- requirements
Module: output_requantizer

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 32, meaning input sample width (signed fixed-point, matches matrix_multiply OUTPUT_WIDTH).
REQ-002 The block SHALL have parameter IN_FRAC, default 16, meaning input fractional bits (ap_fixed<32,16>).
REQ-003 The block SHALL have parameter OUT_WIDTH, default 16, meaning output sample width.
REQ-004 The block SHALL have parameter OUT_FRAC, default 10, meaning output fractional bits (ap_fixed<16,6>); IN_FRAC > OUT_FRAC is required.
REQ-005 The block SHALL have parameter ROW_LEN, default 512, meaning beats per row; TLAST marks each row end.
REQ-006 The block SHALL have port ap_clk  in  1  sole clock, rising edge.
REQ-007 The block SHALL have port ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 The block SHALL have port s_axis_input_tdata  in  IN_WIDTH  input sample, consumed from matrix_multiply m_axis_output.
REQ-009 The block SHALL have ports s_axis_input_tvalid  in  1 and s_axis_input_tready  out  1, the input handshake.
REQ-010 The block SHALL have port m_axis_output_tdata  out  OUT_WIDTH  requantized sample.
REQ-011 The block SHALL have ports m_axis_output_tvalid  out  1, m_axis_output_tready  in  1, m_axis_output_tlast  out  1.

Function
REQ-012 A transfer SHALL occur on a rising edge where tvalid and tready are both 1, and only then.
REQ-013 The block SHALL be a 2-stage pipeline with one shared advance enable, en = !m_axis_output_tvalid || m_axis_output_tready.
REQ-014 s_axis_input_tready SHALL equal en; this combinational path from m_axis_output_tready is permitted.
REQ-015 With m_axis_output_tready held at 1, latency SHALL be 2 cycles from input transfer to output valid, at a throughput of 1 sample per cycle.
REQ-016 When en=0, both stages SHALL hold data, valid and last unchanged, and m_axis_output_tdata SHALL stay stable while tvalid=1.
REQ-017 Stage 1 SHALL compute r = x + 2^(SHIFT-1), then arithmetic right shift by SHIFT, where SHIFT = IN_FRAC-OUT_FRAC and x is sign-extended to IN_WIDTH+1 bits so the add cannot overflow.
REQ-018 Rounding SHALL be round-half-up toward +inf, so -0.5 LSB rounds to 0.
REQ-019 Stage 2 SHALL saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and set an internal sat flag when clipping occurs.
REQ-020 A beat counter SHALL count 0..ROW_LEN-1, increment on each input transfer, and wrap to 0 after ROW_LEN-1.
REQ-021 The input beat accepted at count ROW_LEN-1 SHALL carry last=1, pipelined alongside its data to m_axis_output_tlast.
REQ-022 Pipeline bubbles (tvalid=0 input while en=1) SHALL propagate as invalid stages and SHALL NOT advance the counter.

Reset
REQ-023 Assertion of ap_rst_n=0 SHALL asynchronously clear all outputs: m_axis_output_tvalid=0, tdata=0, tlast=0, beat counter=0, stage valids=0.
REQ-024 Reset mid-row SHALL discard in-flight samples, and the first transfer after deassertion SHALL be counted as beat 0.
REQ-025 s_axis_input_tready SHALL be 1 during reset, per REQ-014, but no transfer SHALL be captured while ap_rst_n=0.

Configuration
REQ-026 With macro OUTPUT_REQUANT_SAT_CNT_EN defined, the block SHALL add ports sat_clr  in  1 and sat_count  out  16.
REQ-027 With that macro defined, sat_count SHALL increment by 1 per output transfer whose sample saturated, stick at 0xFFFF, reset to 0, and clear to 0 on sat_clr; clear SHALL win over a simultaneous increment.
REQ-028 Without that macro, those ports and the counter SHALL NOT exist and saturation behaviour SHALL be unchanged.

Verification
REQ-029 The bench SHALL cover: input 0x00010000, tready=1 -> output 0x0400 exactly 2 cycles later.
REQ-030 The bench SHALL cover: inputs 0x0000001F, 0x00000020, 0xFFFFFFE0 -> outputs 0x0000, 0x0001, 0x0000.
REQ-031 The bench SHALL cover: inputs 0x7FFFFFFF, 0x80000000 -> 0x7FFF, 0x8000; with macro defined, sat_count=2, then pulse sat_clr concurrent with a saturating beat -> sat_count=0.
REQ-032 The bench SHALL cover: 1024 back-to-back beats -> tlast=1 exactly on beats 511 and 1023, and no other tlast.
REQ-033 The bench SHALL cover: random m_axis_output_tready throttling (50%) plus random input tvalid -> output sequence equals the reference model, with no drop, duplicate or data change while stalled.
REQ-034 The bench SHALL cover: assert ap_rst_n=0 at beat 300 then release -> tvalid=0 during reset, and the next row's tlast falls on the 512th beat after release.
